// File: rtl/bcrypt_eks_engine.sv
// bcrypt_eks_engine: bcrypt expensive key schedule (2^cost iterations) over external P/key/salt and S-box RAMs
module bcrypt_eks_engine #(
  parameter int RD_LAT    = 1,
  parameter int COST_MIN  = 4,
  parameter int COST_MAX  = 31,
  parameter int KEY_BASE  = 18,
  parameter int SALT_BASE = 36,
  parameter int COST_ADDR = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] iter,
  output logic        p_we_a,
  output logic        p_we_b,
  output logic [5:0]  p_addr_a,
  output logic [5:0]  p_addr_b,
  output logic [31:0] p_din_a,
  output logic [31:0] p_din_b,
  input  logic [31:0] p_dout_a,
  input  logic [31:0] p_dout_b,
  output logic        s_we_a,
  output logic        s_we_b,
  output logic [9:0]  s_addr_a,
  output logic [9:0]  s_addr_b,
  output logic [31:0] s_din_a,
  output logic [31:0] s_din_b,
  input  logic [31:0] s_dout_a,
  input  logic [31:0] s_dout_b
);
  typedef enum logic [3:0] {
    IDLE, LD_COST, CHECK, XOR_KEY, ENC_INIT, FEISTEL, STORE, XOR_SALT, NEXT_ITER, DONE
  } state_t;
  localparam logic [1:0]  LAT     = 2'(RD_LAT);
  localparam logic [1:0]  RND_END = 2'(2 * RD_LAT - 1);
  localparam logic [31:0] CMIN    = 32'(COST_MIN);
  localparam logic [31:0] CMAX    = 32'(COST_MAX);
  state_t      state;
  logic [1:0]  wc;
  logic [4:0]  idx;
  logic [9:0]  blk;
  logic        salt;
  logic        first;
  logic [31:0] x_reg;
  logic [31:0] b_reg;
  logic [31:0] s01;
  logic [31:0] count;
  logic [4:0]  cost;
  logic        cost_ok;
  logic [31:0] f_comb;
  logic [31:0] x_comb;
  logic [31:0] l_out;
  logic [15:0] x_hi;
  logic [8:0]  sblk;
  // Round state is (x, b): x = L^P[r] of the round in flight, b = R feeding it.
  // The previous round's F result is folded in combinationally when the S2/S3 data lands.
  assign f_comb = (s01 ^ s_dout_a) + s_dout_b;
  assign x_comb = b_reg ^ (first ? 32'd0 : f_comb) ^ p_dout_a;
  assign l_out  = x_reg ^ p_dout_b;
  assign x_hi   = wc == 2'd0 ? x_comb[31:16] : x_reg[31:16];
  assign sblk   = 9'(blk - 10'd9);
  always_comb begin
    p_we_a   = 1'b0;
    p_we_b   = 1'b0;
    p_addr_a = '0;
    p_addr_b = '0;
    p_din_a  = '0;
    p_din_b  = '0;
    s_we_a   = 1'b0;
    s_we_b   = 1'b0;
    s_addr_a = '0;
    s_addr_b = '0;
    s_din_a  = '0;
    s_din_b  = '0;
    unique case (state)
      LD_COST: p_addr_a = 6'(COST_ADDR);
      XOR_KEY, XOR_SALT: begin
        p_addr_a = 6'(idx);
        p_addr_b = state == XOR_KEY ? 6'(KEY_BASE) + 6'(idx) : 6'(SALT_BASE) + {4'd0, idx[1:0]};
        p_we_a   = wc == LAT;
        p_din_a  = wc == LAT ? p_dout_a ^ p_dout_b : '0;
      end
      ENC_INIT: p_addr_b = 6'd17;
      FEISTEL: begin
        p_addr_a = 6'(idx) + 6'd1;
        p_addr_b = 6'd17;
        s_addr_a = wc < LAT ? {2'd0, x_hi[15:8]} : {2'd2, x_reg[15:8]};
        s_addr_b = wc < LAT ? {2'd1, x_hi[7:0]}  : {2'd3, x_reg[7:0]};
      end
      STORE: begin
        if (blk < 10'd9) begin
          p_we_a   = 1'b1;
          p_we_b   = 1'b1;
          p_addr_a = {blk[4:0], 1'b0};
          p_addr_b = {blk[4:0], 1'b1};
          p_din_a  = l_out;
          p_din_b  = x_comb;
        end else begin
          s_we_a   = 1'b1;
          s_we_b   = 1'b1;
          s_addr_a = {sblk, 1'b0};
          s_addr_b = {sblk, 1'b1};
          s_din_a  = l_out;
          s_din_b  = x_comb;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      iter    <= '0;
      wc      <= '0;
      idx     <= '0;
      blk     <= '0;
      salt    <= 1'b0;
      first   <= 1'b0;
      x_reg   <= '0;
      b_reg   <= '0;
      s01     <= '0;
      count   <= '0;
      cost    <= '0;
      cost_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            state <= LD_COST;
            busy  <= 1'b1;
            err   <= 1'b0;
            iter  <= '0;
            wc    <= '0;
          end
          LD_COST: if (wc == LAT) begin
            cost    <= p_dout_a[4:0];
            cost_ok <= p_dout_a >= CMIN && p_dout_a <= CMAX;
            wc      <= '0;
            state   <= CHECK;
          end else wc <= wc + 2'd1;
          CHECK: if (!cost_ok) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= 32'd1 << cost;
            idx   <= '0;
            salt  <= 1'b0;
            state <= XOR_KEY;
          end
          XOR_KEY, XOR_SALT: if (wc == LAT) begin
            wc <= '0;
            if (idx == 5'd17) begin
              idx   <= '0;
              blk   <= '0;
              x_reg <= '0;
              b_reg <= '0;
              first <= 1'b1;
              state <= ENC_INIT;
            end else idx <= idx + 5'd1;
          end else wc <= wc + 2'd1;
          ENC_INIT: if (wc == LAT) begin
            wc    <= '0;
            idx   <= '0;
            state <= FEISTEL;
          end else wc <= wc + 2'd1;
          FEISTEL: begin
            if (wc == 2'd0) begin
              x_reg <= x_comb;
              b_reg <= x_reg;
              first <= 1'b0;
            end
            if (wc == LAT) s01 <= s_dout_a + s_dout_b;
            if (wc == RND_END) begin
              wc <= '0;
              if (idx == 5'd15) state <= STORE;
              else idx <= idx + 5'd1;
            end else wc <= wc + 2'd1;
          end
          STORE: begin
            b_reg <= l_out;
            x_reg <= x_comb;
            first <= 1'b1;
            blk   <= blk + 10'd1;
            if (blk < 10'd520) state <= ENC_INIT;
            else if (salt) state <= NEXT_ITER;
            else begin
              salt  <= 1'b1;
              idx   <= '0;
              state <= XOR_SALT;
            end
          end
          NEXT_ITER: begin
            iter  <= iter + 32'd1;
            count <= count - 32'd1;
            if (count == 32'd1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              salt  <= 1'b0;
              idx   <= '0;
              state <= XOR_KEY;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/bcrypt_eks_engine.md
# bcrypt_eks_engine

Parametrised successor to the single-cost bcrypt key-schedule loop. It runs the bcrypt expensive key schedule for 2^cost iterations over an external P/key/salt RAM and a 1024-word S-box RAM. It adds configurable RAM read latency, cost range checking, abort, a start/done pulse handshake and a live iteration counter. It sits between the host register bank and the two dual-port BRAMs of one bcrypt core.

## Interface
- RD_LAT, 1: RAM read latency in cycles (legal 1 or 2); all wait states scale with it.
- COST_MIN, 4: smallest accepted cost value.
- COST_MAX, 31: largest accepted cost value (≤31).
- KEY_BASE, 18: P-RAM address of the 18 expanded-key words.
- SALT_BASE, 36: P-RAM address of the 4 salt words.
- COST_ADDR, 40: P-RAM address of the cost word.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle.
- busy  out  1  high from the cycle after start is accepted until done or err.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky cost-range error; cleared by the next accepted start.
- iter  out  32  completed iterations of the current run.
- p_we_a, p_we_b  out  1  P-RAM write enables.
- p_addr_a, p_addr_b  out  6  P-RAM addresses.
- p_din_a, p_din_b  out  32  P-RAM write data.
- p_dout_a, p_dout_b  in  32  P-RAM read data, RD_LAT cycles after the address.
- s_we_a, s_we_b  out  1  S-RAM write enables.
- s_addr_a, s_addr_b  out  10  S-RAM addresses; bits [9:8] select the S-box.
- s_din_a, s_din_b  out  32  S-RAM write data.
- s_dout_a, s_dout_b  in  32  S-RAM read data.

## Operation
- States: IDLE, LD_COST, CHECK, XOR_KEY, ENC_INIT, FEISTEL, STORE, XOR_SALT, NEXT_ITER, DONE.
- IDLE → LD_COST on start. Clears iter and err. busy rises next cycle.
- LD_COST: reads COST_ADDR. cost = dout[4:0]; dout[31:5] must be 0.
- CHECK: if the cost is out of range, set err, drop busy and return to IDLE without a done pulse. Otherwise load the down-counter with 1<<cost and go to XOR_KEY.
- XOR_KEY: for i = 0..17, P[i] ^= P[KEY_BASE+i]. Each word is a read followed by a write-back on port a. Then L = R = 0, blk = 0, and go to ENC_INIT.
- ENC_INIT / FEISTEL: standard 16-round Blowfish encryption of (L,R) using the current P and S.
  - Each round: L ^= P[i]; R ^= F(L); swap.
  - F(x) = ((S0[x31:24] + S1[x23:16]) ^ S2[x15:8]) + S3[x7:0], all mod 2^32.
  - After round 16: undo the swap, then R ^= P[16], L ^= P[17].
- STORE: writes L on port a and R on port b in the same cycle.
  - blk < 9: P[2blk] and P[2blk+1].
  - 9 ≤ blk < 521: S[2(blk−9)] and S[2(blk−9)+1].
  - Then blk++. If blk < 520 before the increment, go to ENC_INIT with L,R chained; otherwise the phase ends.
- Phase order per iteration: key phase (XOR_KEY, then 521 blocks), then salt phase (XOR_SALT, then 521 blocks).
- XOR_SALT: P[i] ^= P[SALT_BASE + (i mod 4)]. L,R are reset to 0 before the salt-phase blocks.
- NEXT_ITER: iter++ and count−−. If count is 0, go to DONE; otherwise go to XOR_KEY.
- DONE: pulse done for 1 cycle, drop busy, go to IDLE.
- Write enables may be high only in XOR_KEY/XOR_SALT write cycles and STORE. All other cycles drive addresses only, with we = 0 and din = 0.
- abort (any state except IDLE): next state is IDLE, busy = 0, no done pulse, err unchanged. RAM contents are left partially updated.
- rst (any state): IDLE, busy = done = err = 0, iter = 0, all we = 0. rst has priority over abort and start.
- start during busy is ignored. start and abort in the same IDLE cycle: abort wins, and the start is dropped.

## Timing
- Reset values: busy 0, done 0, err 0, iter 0, all we 0, all addr 0, all din 0.
- LD_COST: RD_LAT+1 cycles. CHECK: 1 cycle.
- XOR phase: 18×(RD_LAT+1) cycles.
- Block: ENC_INIT (RD_LAT+1) + FEISTEL 32×RD_LAT + STORE 1 = 2 + 33×RD_LAT cycles (35 at RD_LAT=1, 68 at RD_LAT=2).
- Phase = 18(RD_LAT+1) + 521(2 + 33·RD_LAT). Iteration = 2·phase + 1, which is 36543 cycles at RD_LAT=1.
- Total from the start-accept edge to the done pulse = RD_LAT + 2 + 2^cost × iteration. At RD_LAT=1, cost=4 this is 584691 cycles.
- iter updates in the NEXT_ITER cycle and holds its final value after done until the next start.
- Error path: err and busy=0 appear RD_LAT+2 cycles after start is accepted.

## Test plan
- RD_LAT=1, cost=4, fixed key/salt/P/S image: done after exactly 584691 cycles. Final P/S RAM matches the C reference model bit-exactly, iter = 16.
- RD_LAT=2, same image with cost=4: RAM image identical to the RD_LAT=1 run. Done after 4 + 16×(2×(54 + 521×68) + 1) cycles.
- Cost words 3, 32 and 0x00000104: err=1, no done, no RAM writes, busy low 3 cycles after start (RD_LAT=1).
- Abort at cycle 1000 of a cost=4 run: busy=0 next cycle, done never pulses, iter=0. A new start with the RAM reloaded completes correctly.
- rst mid-STORE: all we=0 on the next cycle and outputs return to reset values. A second start with the same image still matches the model.
- start pulses while busy, and start+abort together in IDLE: both ignored, and run timing is unchanged.
